// File: rtl/aes_small_pkg.sv
// rtl/aes_small_pkg.sv - shared types and default timing for the small AES scheduler
package aes_small_pkg;

    localparam int DEF_LOAD_CYCLES  = 16;
    localparam int DEF_CORE_LATENCY = 22;
    localparam int DEF_KEY_INIT     = 17;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_OUT
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-grant history
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    input  logic update,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant0 = en && valid0 && (!valid1 || last_grant);
        grant1 = en && valid1 && !grant0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/aes_small_scheduler.sv
// rtl/aes_small_scheduler.sv - key-init sequencer and two-port block arbiter for the AES core
module aes_small_scheduler
    import aes_small_pkg::*;
#(
    parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
    parameter int CORE_LATENCY = DEF_CORE_LATENCY,
    parameter int KEY_INIT     = DEF_KEY_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  block_t      req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  block_t      req1_data,
    output logic        req1_ready,
    output logic        core_load,
    output logic        core_key_rst,
    output logic [31:0] core_x,
    output logic [31:0] core_y,
    output logic [31:0] core_z,
    output logic [31:0] core_w,
    input  block_t      core_result,
    output logic        out_valid,
    input  logic        out_ready,
    output block_t      out_data,
    output logic        out_id,
    output logic        busy
);

    localparam int CW = $clog2(max3(LOAD_CYCLES, CORE_LATENCY, KEY_INIT) + 1);
    localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_INIT);
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(CORE_LATENCY - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          grant0;
    logic          grant1;
    logic          xfer;
    block_t        core_blk;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state == ST_IDLE),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .update (xfer),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (cnt == KEY_LAST)  state_nxt = ST_IDLE;
            ST_IDLE: if (xfer)             state_nxt = ST_LOAD;
            ST_LOAD: if (cnt == LOAD_LAST) state_nxt = ST_WAIT;
            ST_WAIT: if (cnt == WAIT_LAST) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready)        state_nxt = ST_IDLE;
            default:                       state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        core_load    = (state == ST_LOAD);
        core_key_rst = (state == ST_INIT) && (cnt == KEY_LAST);
        out_valid    = (state == ST_OUT);
        busy         = (state != ST_IDLE);
    end

    // Restarts from zero on every state change; only the timed states advance it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == ST_INIT || state == ST_LOAD || state == ST_WAIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_blk <= '0;
            out_data <= '0;
            out_id   <= 1'b0;
        end else begin
            if (xfer) begin
                core_blk <= grant1 ? req1_data : req0_data;
                out_id   <= grant1;
            end
            if (state == ST_WAIT && cnt == WAIT_LAST) begin
                out_data <= core_result;
            end
        end
    end

    assign core_x = core_blk[127:96];
    assign core_y = core_blk[95:64];
    assign core_z = core_blk[63:32];
    assign core_w = core_blk[31:0];

endmodule
